uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter Out_Data_width, default 8, data bits per frame and P_DATA width.
REQ-002 Parameter Prescale_Width, default 6, width of the Prescale input.
REQ-003 CLK  input  1  oversampling clock, Prescale × bit rate; all logic on rising edge.
REQ-004 RST  input  1  asynchronous, active-low reset.
REQ-005 RX_IN  input  1  serial line, idle high.
REQ-006 PAR_EN  input  1  1 = parity bit present after data.
REQ-007 PAR_TYP  input  1  0 = even parity, 1 = odd parity.
REQ-008 Prescale  input  Prescale_Width  CLK cycles per bit; supported values 8, 16, 32.
REQ-009 P_DATA  output  Out_Data_width  received data byte.
REQ-010 Data_Valid  output  1  one-CLK pulse for an error-free frame.
REQ-011 par_err  output  1  parity mismatch flag.
REQ-012 stp_err  output  1  stop bit sampled low.

Function
REQ-013 Frame format: start (0), Out_Data_width data bits LSB first, optional parity, one stop (1).
REQ-014 FSM states: IDLE, START, DATA, PARITY, STOP.
REQ-015 Edge counter: counts 0..Prescale-1 within each bit; bit counter advances on edge count Prescale-1.
REQ-016 Bit value = majority of three samples taken at edge counts Prescale/2-1, Prescale/2, Prescale/2+1; decision is available from edge count Prescale/2+1.
REQ-017 IDLE: leave for START on the first CLK where RX_IN = 0; edge counter starts at 0 on that cycle.
REQ-018 START: a sampled start value of 1 is a glitch; return to IDLE at end of bit with no outputs changed.
REQ-019 DATA: shift each sampled bit into a deserializer at the bit decision point, LSB first.
REQ-020 P_DATA is the deserializer contents.
REQ-021 P_DATA holds the full byte from the 8th data bit decision until the first data bit of the next frame.
REQ-022 After DATA, go to PARITY if PAR_EN = 1, else go to STOP.
REQ-023 PARITY: expected bit = XOR of P_DATA for even parity, XNOR for odd parity.
REQ-024 PARITY mismatch: par_err rises at the parity decision point; at end of the parity bit, go to IDLE and skip STOP.
REQ-025 PARITY match: go to STOP.
REQ-026 STOP: if the sampled bit = 0, stp_err rises at the decision point.
REQ-027 STOP, last edge: Data_Valid pulses high for exactly one CLK if par_err = 0 and stp_err = 0; then go to IDLE.
REQ-028 par_err and stp_err are sticky until the next valid start detection or reset.
REQ-029 Data_Valid is never asserted for a frame with either error set.
REQ-030 Back-to-back frames: if RX_IN is already low on return to IDLE (including after a failed stop), the next frame's start is detected immediately.
REQ-031 PAR_EN, PAR_TYP and Prescale are sampled only in IDLE; changes mid-frame take effect at the next frame.

Reset
REQ-032 RST = 0 asynchronously forces: FSM to IDLE, counters 0, P_DATA = 0, Data_Valid = 0, par_err = 0, stp_err = 0.
REQ-033 Reset asserted mid-frame aborts the frame with no Data_Valid.
REQ-034 After reset release, the receiver waits for a new falling edge of RX_IN.

Verification
REQ-035 Prescale 8, PAR_EN 0; serial bits 1,0,0,1,1,0,0,1 with stop = 0 -> P_DATA = 8'b10011001, stp_err rises, no Data_Valid.
REQ-036 Prescale 8, PAR_EN 1, even; same data, parity bit 1 -> par_err rises, no Data_Valid, FSM returns to IDLE.
REQ-037 Even parity, two back-to-back frames: 8'b10011001 with parity 0, then bits 1,0,1,0,1,0,1,0 with parity 0, stops 1 -> P_DATA 8'b10011001 then 8'b01010101, one Data_Valid pulse each, no errors.
REQ-038 Frame 1 with wrong parity, then a correct frame 2 -> par_err on frame 1; frame 2 clears par_err, Data_Valid pulses, P_DATA = 8'b01010101.
REQ-039 Frame 1 with stop = 0, immediately followed by frame 2 with a correct stop -> stp_err on frame 1; frame 2 is received with P_DATA = 8'b01010101 and Data_Valid.
REQ-040 Odd parity with Prescale 16 and 32 -> correct P_DATA; parity bit = ~^data is accepted, an inverted parity bit sets par_err.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: oversampled UART receiver.
// A falling edge on the idle-high line starts a frame. Each bit is Prescale CLK
// cycles long. The bit value is a 2-of-3 majority vote taken around mid-bit.
// The frame is: start bit, Out_Data_width data bits LSB first, an optional parity
// bit and one stop bit. The recovered byte is presented on P_DATA.
// Data_Valid pulses for one cycle only for a frame without errors.
module uart_rx #(
    parameter int Out_Data_width = 8,
    parameter int Prescale_Width = 6
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      RX_IN,
    input  logic                      PAR_EN,
    input  logic                      PAR_TYP,
    input  logic [Prescale_Width-1:0] Prescale,
    output logic [Out_Data_width-1:0] P_DATA,
    output logic                      Data_Valid,
    output logic                      par_err,
    output logic                      stp_err
);

    localparam int BitCntW = (Out_Data_width > 1) ? $clog2(Out_Data_width) : 1;
    localparam logic [BitCntW-1:0] LastBit = BitCntW'(Out_Data_width - 1);
    localparam logic [Prescale_Width-1:0] PsOne = Prescale_Width'(1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_e;

    state_e                      r_state;
    logic [Prescale_Width-1:0]   r_edgeCnt;
    logic [BitCntW-1:0]          r_bitCnt;
    logic [Prescale_Width-1:0]   r_prescale;
    logic                        r_parEn;
    logic                        r_parTyp;
    logic                        r_glitch;
    logic                        r_samp0;
    logic                        r_samp1;
    logic                        r_armed;
    logic [Out_Data_width-1:0]   r_pData;
    logic                        r_dataValid;
    logic                        r_parErr;
    logic                        r_stpErr;

    logic [Prescale_Width-1:0]   w_half;
    logic [Prescale_Width-1:0]   w_samp0Pt;
    logic [Prescale_Width-1:0]   w_decisionPt;
    logic [Prescale_Width-1:0]   w_lastEdge;
    logic                        w_isDecision;
    logic                        w_isLastEdge;
    logic                        w_bitVal;
    logic                        w_parExpected;
    logic                        w_startDetect;

    // The three sample points sit around mid-bit. The bit decision is made on the
    // cycle of the third sample, so the decision uses that cycle's RX_IN directly.
    assign w_half        = r_prescale >> 1;
    assign w_samp0Pt     = w_half - PsOne;
    assign w_decisionPt  = w_half + PsOne;
    assign w_lastEdge    = r_prescale - PsOne;
    assign w_isDecision  = (r_edgeCnt == w_decisionPt);
    assign w_isLastEdge  = (r_edgeCnt == w_lastEdge);
    assign w_bitVal      = (r_samp0 & r_samp1) | (r_samp0 & RX_IN) | (r_samp1 & RX_IN);
    assign w_parExpected = r_parTyp ? ~(^r_pData) : (^r_pData);
    assign w_startDetect = (RX_IN == 1'b0) && r_armed;

    assign P_DATA     = r_pData;
    assign Data_Valid = r_dataValid;
    assign par_err    = r_parErr;
    assign stp_err    = r_stpErr;

    // The line must be seen high once after reset before a start can be accepted.
    // A line already low at reset release therefore does not fake a start edge.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_armed <= 1'b0;
        end else if (RX_IN) begin
            r_armed <= 1'b1;
        end
    end

    // Capture the first two majority samples of the current bit.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_samp0 <= 1'b1;
            r_samp1 <= 1'b1;
        end else if (r_state != IDLE) begin
            if (r_edgeCnt == w_samp0Pt) begin
                r_samp0 <= RX_IN;
            end
            if (r_edgeCnt == w_half) begin
                r_samp1 <= RX_IN;
            end
        end
    end

    // Receiver FSM: frame sequencing, deserializer, error flags and Data_Valid.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state     <= IDLE;
            r_edgeCnt   <= '0;
            r_bitCnt    <= '0;
            r_prescale  <= '0;
            r_parEn     <= 1'b0;
            r_parTyp    <= 1'b0;
            r_glitch    <= 1'b0;
            r_pData     <= '0;
            r_dataValid <= 1'b0;
            r_parErr    <= 1'b0;
            r_stpErr    <= 1'b0;
        end else begin
            r_dataValid <= 1'b0;

            if (r_state != IDLE) begin
                r_edgeCnt <= w_isLastEdge ? '0 : (r_edgeCnt + PsOne);
            end

            case (r_state)
                IDLE: begin
                    r_edgeCnt <= '0;
                    r_bitCnt  <= '0;
                    if (w_startDetect) begin
                        r_state    <= START;
                        r_edgeCnt  <= PsOne;
                        r_prescale <= Prescale;
                        r_parEn    <= PAR_EN;
                        r_parTyp   <= PAR_TYP;
                        r_glitch   <= 1'b0;
                    end
                end

                START: begin
                    if (w_isDecision) begin
                        if (w_bitVal) begin
                            r_glitch <= 1'b1;
                        end else begin
                            r_parErr <= 1'b0;
                            r_stpErr <= 1'b0;
                        end
                    end
                    if (w_isLastEdge) begin
                        r_bitCnt <= '0;
                        r_state  <= r_glitch ? IDLE : DATA;
                    end
                end

                DATA: begin
                    if (w_isDecision) begin
                        r_pData <= {w_bitVal, r_pData[Out_Data_width-1:1]};
                    end
                    if (w_isLastEdge) begin
                        if (r_bitCnt == LastBit) begin
                            r_state <= r_parEn ? PARITY : STOP;
                        end else begin
                            r_bitCnt <= r_bitCnt + 1'b1;
                        end
                    end
                end

                PARITY: begin
                    if (w_isDecision && (w_bitVal != w_parExpected)) begin
                        r_parErr <= 1'b1;
                    end
                    if (w_isLastEdge) begin
                        r_state <= r_parErr ? IDLE : STOP;
                    end
                end

                STOP: begin
                    if (w_isDecision && !w_bitVal) begin
                        r_stpErr <= 1'b1;
                    end
                    if (w_isLastEdge) begin
                        r_dataValid <= !r_parErr && !r_stpErr;
                        r_state     <= IDLE;
                    end
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx.
// Frames are built from the frame-format rules: start, data bits LSB first,
// optional parity from a ones count, and stop. Each bit's line value is held
// for Prescale cycles. One of the three mid-bit samples may be inverted. The
// expected byte, flags and Data_Valid pulse count come from those rules.
module tb_uart_rx;

    localparam int DataW = 8;
    localparam int PsW   = 6;

    logic             CLK;
    logic             RST;
    logic             RX_IN;
    logic             PAR_EN;
    logic             PAR_TYP;
    logic [PsW-1:0]   Prescale;
    logic [DataW-1:0] P_DATA;
    logic             Data_Valid;
    logic             par_err;
    logic             stp_err;

    int               vectorCount = 0;
    int               missCount   = 0;
    int               dvCycles    = 0;
    logic [DataW-1:0] dvData      = '0;

    uart_rx #(
        .Out_Data_width (DataW),
        .Prescale_Width (PsW)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .RX_IN      (RX_IN),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .Prescale   (Prescale),
        .P_DATA     (P_DATA),
        .Data_Valid (Data_Valid),
        .par_err    (par_err),
        .stp_err    (stp_err)
    );

    // Free-running oversampling clock.
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Count every cycle in which Data_Valid is high, and capture the byte shown with it.
    always @(negedge CLK) begin
        if (Data_Valid) begin
            dvCycles = dvCycles + 1;
            dvData   = P_DATA;
        end
    end

    // Stop the run if it stalls.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectorCount = vectorCount + 1;
        if (observed !== expected) begin
            missCount = missCount + 1;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic int pickPrescale();
        int sel;
        sel = $urandom_range(0, 2);
        return (sel == 0) ? 8 : ((sel == 1) ? 16 : 32);
    endfunction

    // Drive one bit for ps cycles. When noisy is set, invert the line on one of
    // the three majority sample points.
    task automatic driveBit(input logic v, input int ps, input logic noisy);
        int noisePos;
        noisePos = noisy ? (ps / 2 - 1 + $urandom_range(0, 2)) : -1;
        for (int c = 0; c < ps; c++) begin
            RX_IN = (c == noisePos) ? ~v : v;
            @(negedge CLK);
        end
    endtask

    // Send one whole frame and compare the outcome with the frame rules.
    task automatic applyStimulus(input logic [DataW-1:0] data, input logic parEn, input logic parTyp,
                                 input int ps, input logic badPar, input logic stopBit,
                                 input logic noisy, input string tag);
        int   dvBefore;
        int   ones;
        logic parBit;
        logic expDv;
        logic expParErr;
        logic expStpErr;

        dvBefore = dvCycles;
        ones     = $countones(data);
        parBit   = (parTyp ? (ones % 2 == 0) : (ones % 2 == 1)) ^ badPar;

        PAR_EN   = parEn;
        PAR_TYP  = parTyp;
        Prescale = PsW'(ps);
        driveBit(1'b0, ps, noisy);

        PAR_EN   = 1'($urandom);
        PAR_TYP  = 1'($urandom);
        Prescale = PsW'(pickPrescale());

        for (int i = 0; i < DataW; i++) begin
            driveBit(data[i], ps, noisy);
        end
        if (parEn) begin
            driveBit(parBit, ps, noisy);
        end
        driveBit(stopBit, ps, noisy && !(parEn && badPar));
        RX_IN = 1'b1;
        #1;

        expParErr = parEn && badPar;
        expStpErr = !expParErr && !stopBit;
        expDv     = !expParErr && !expStpErr;

        checkOutput({tag, ".data"}, 32'(P_DATA), 32'(data));
        checkOutput({tag, ".par_err"}, 32'(par_err), 32'(expParErr));
        checkOutput({tag, ".stp_err"}, 32'(stp_err), 32'(expStpErr));
        checkOutput({tag, ".dv_cycles"}, 32'(dvCycles - dvBefore), 32'(expDv));
        if (expDv) begin
            checkOutput({tag, ".dv_data"}, 32'(dvData), 32'(data));
        end
    endtask

    task automatic idleBits(input int bits, input int ps);
        RX_IN = 1'b1;
        repeat (bits * ps) @(negedge CLK);
    endtask

    // A one-cycle low pulse must not change any output.
    task automatic applyGlitch(input int ps);
        logic [DataW-1:0] dataBefore;
        logic             parBefore;
        logic             stpBefore;
        int               dvBefore;
        dataBefore = P_DATA;
        parBefore  = par_err;
        stpBefore  = stp_err;
        dvBefore   = dvCycles;
        Prescale   = PsW'(ps);
        RX_IN      = 1'b0;
        @(negedge CLK);
        RX_IN      = 1'b1;
        repeat (ps + 2) @(negedge CLK);
        #1;
        checkOutput("glitch.data", 32'(P_DATA), 32'(dataBefore));
        checkOutput("glitch.par_err", 32'(par_err), 32'(parBefore));
        checkOutput("glitch.stp_err", 32'(stp_err), 32'(stpBefore));
        checkOutput("glitch.dv_cycles", 32'(dvCycles - dvBefore), 32'd0);
    endtask

    // Main sequence: reset, directed frames, reset abort, glitch, random frames.
    initial begin
        int dvMark;
        int ps;
        logic parEn;
        logic badPar;
        logic stopBit;

        RST      = 1'b0;
        RX_IN    = 1'b1;
        PAR_EN   = 1'b0;
        PAR_TYP  = 1'b0;
        Prescale = PsW'(8);
        #12;
        checkOutput("reset.data", 32'(P_DATA), 32'd0);
        checkOutput("reset.dv", 32'(Data_Valid), 32'd0);
        checkOutput("reset.par_err", 32'(par_err), 32'd0);
        checkOutput("reset.stp_err", 32'(stp_err), 32'd0);
        @(negedge CLK);
        RST = 1'b1;
        idleBits(1, 8);

        applyStimulus(8'b10011001, 1'b0, 1'b0, 8, 1'b0, 1'b0, 1'b0, "stopErr8");
        idleBits(1, 8);
        applyStimulus(8'b10011001, 1'b1, 1'b0, 8, 1'b1, 1'b1, 1'b0, "parErrEven8");
        idleBits(1, 8);
        applyStimulus(8'b10011001, 1'b1, 1'b0, 8, 1'b0, 1'b1, 1'b0, "b2bEvenA");
        applyStimulus(8'b01010101, 1'b1, 1'b0, 8, 1'b0, 1'b1, 1'b0, "b2bEvenB");
        idleBits(1, 8);
        applyStimulus(8'b10011001, 1'b1, 1'b0, 8, 1'b1, 1'b1, 1'b0, "parThenOkA");
        applyStimulus(8'b01010101, 1'b1, 1'b0, 8, 1'b0, 1'b1, 1'b0, "parThenOkB");
        idleBits(1, 8);
        applyStimulus(8'b10011001, 1'b0, 1'b0, 8, 1'b0, 1'b0, 1'b0, "stpThenOkA");
        applyStimulus(8'b01010101, 1'b0, 1'b0, 8, 1'b0, 1'b1, 1'b0, "stpThenOkB");
        idleBits(1, 8);
        applyStimulus(8'hA7, 1'b1, 1'b1, 16, 1'b0, 1'b1, 1'b0, "odd16Ok");
        applyStimulus(8'hA7, 1'b1, 1'b1, 16, 1'b1, 1'b1, 1'b0, "odd16Bad");
        idleBits(1, 16);
        applyStimulus(8'h3C, 1'b1, 1'b1, 32, 1'b0, 1'b1, 1'b0, "odd32Ok");
        applyStimulus(8'h3C, 1'b1, 1'b1, 32, 1'b1, 1'b1, 1'b0, "odd32Bad");
        idleBits(1, 32);

        // A stop error leaves stp_err set. Then reset in the middle of the next start bit.
        applyStimulus(8'hC3, 1'b0, 1'b0, 8, 1'b0, 1'b0, 1'b0, "preReset");
        dvMark   = dvCycles;
        Prescale = PsW'(8);
        PAR_EN   = 1'b0;
        RX_IN    = 1'b0;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        #2;
        checkOutput("midReset.data", 32'(P_DATA), 32'd0);
        checkOutput("midReset.dv", 32'(Data_Valid), 32'd0);
        checkOutput("midReset.par_err", 32'(par_err), 32'd0);
        checkOutput("midReset.stp_err", 32'(stp_err), 32'd0);
        repeat (3) @(negedge CLK);
        RST = 1'b1;
        repeat (3 * 8) @(negedge CLK);
        idleBits(2, 8);
        #1;
        checkOutput("postReset.dv_cycles", 32'(dvCycles - dvMark), 32'd0);
        applyStimulus(8'b01010101, 1'b0, 1'b0, 8, 1'b0, 1'b1, 1'b0, "postReset");
        idleBits(1, 8);

        applyGlitch(16);
        idleBits(1, 16);
        applyStimulus(8'h5A, 1'b1, 1'b0, 16, 1'b0, 1'b1, 1'b1, "afterGlitch");

        for (int n = 0; n < 40; n++) begin
            ps      = pickPrescale();
            parEn   = 1'($urandom);
            badPar  = parEn && ($urandom_range(0, 3) == 0);
            stopBit = badPar ? 1'b1 : ($urandom_range(0, 4) != 0);
            applyStimulus(8'($urandom), parEn, 1'($urandom), ps, badPar, stopBit,
                          1'($urandom), $sformatf("rand%0d", n));
            idleBits($urandom_range(0, 2), ps);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
